// File: rtl/nrx_video_pkg.sv
// Shared New Rally-X video timing constants and the sync/enable decode used by the scandoubler.
package nrx_video_pkg;

    localparam int PIX_W     = 8;
    localparam int ADDR_W    = 9;
    localparam int BUF_DEPTH = 512;

    localparam logic [8:0] H_TOTAL  = 9'd384;
    localparam logic [8:0] H_ACTIVE = 9'd288;
    localparam logic [8:0] V_ACTIVE = 9'd224;
    localparam logic [8:0] HS_START = 9'd304;
    localparam logic [8:0] HS_END   = 9'd336;
    localparam logic [8:0] VS_START = 9'd240;
    localparam logic [8:0] VS_LINES = 9'd2;
    localparam logic [8:0] VS_END   = VS_START + VS_LINES;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } vtiming_t;

    localparam vtiming_t TIM_BLANK = '{de: 1'b0, hs: 1'b1, vs: 1'b1};

    // The line being read out is vlat-1; at vlat==0 it wraps to 511 and falls outside the active band.
    function automatic vtiming_t timing_at(input logic [8:0] oh, input logic [8:0] vlat,
                                           input logic locked);
        vtiming_t   t;
        logic [8:0] vprev;
        vprev = vlat - 9'd1;
        t.de  = locked && (oh < H_ACTIVE) && (vprev < V_ACTIVE);
        t.hs  = !(locked && (oh >= HS_START) && (oh < HS_END));
        t.vs  = !(locked && (vlat >= VS_START) && (vlat < VS_END));
        return t;
    endfunction

endpackage

// File: rtl/nrx_linebuf.sv
// Ping-pong line store: two 512x8 banks, synchronous write, registered read, one clock.
module nrx_linebuf
    import nrx_video_pkg::*;
(
    input  logic              VCLKx4,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem [0:2*BUF_DEPTH-1];

    always_ff @(posedge VCLKx4) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/nrx_scandoubler.sv
// Line doubler: stores each 15 kHz input line and replays the previous one twice at 2x pixel rate.
module nrx_scandoubler
    import nrx_video_pkg::*;
(
    input  logic       VCLKx4,
    input  logic       RESET,
    input  logic       PIXCE,
    input  logic [8:0] HPOS,
    input  logic [8:0] VPOS,
    input  logic [7:0] POUT,
    output logic [7:0] VOUT,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       DE,
    output logic       OCE,
    output logic       LOCKED
);

    logic [8:0] oh;
    logic [8:0] vlat;
    logic       phase;
    logic       locked;
    logic       line_start;
    logic       wr_en;
    logic [7:0] ramq;
    vtiming_t   tim_s1;

    assign line_start = PIXCE && (HPOS == 9'd0);
    assign wr_en      = PIXCE && (HPOS < H_ACTIVE);

    nrx_linebuf u_linebuf (
        .VCLKx4  (VCLKx4),
        .wr_en   (wr_en),
        .wr_bank (VPOS[0]),
        .wr_addr (HPOS),
        .wr_data (POUT),
        .rd_bank (~vlat[0]),
        .rd_addr (oh),
        .rd_data (ramq)
    );

    // A line start always takes priority over the free-running wrap of the output counter.
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            oh     <= 9'd0;
            vlat   <= 9'd0;
            phase  <= 1'b0;
            locked <= 1'b0;
        end else if (line_start) begin
            oh     <= 9'd0;
            vlat   <= VPOS;
            phase  <= 1'b0;
            locked <= 1'b1;
        end else begin
            phase <= ~phase;
            if (phase && locked) begin
                oh <= (oh == H_TOTAL - 9'd1) ? 9'd0 : oh + 9'd1;
            end
        end
    end

    // Timing decode runs beside the RAM read so both reach the output register together.
    always_ff @(posedge VCLKx4) begin
        if (RESET) begin
            tim_s1 <= TIM_BLANK;
            VOUT   <= 8'd0;
            HSYNC  <= 1'b1;
            VSYNC  <= 1'b1;
            DE     <= 1'b0;
        end else begin
            tim_s1 <= timing_at(oh, vlat, locked);
            if (phase) begin
                VOUT  <= tim_s1.de ? ramq : 8'd0;
                DE    <= tim_s1.de;
                HSYNC <= tim_s1.hs;
                VSYNC <= tim_s1.vs;
            end
        end
    end

    assign OCE    = phase;
    assign LOCKED = locked;

endmodule

// File: tb/tb_nrx_scandoubler.sv
// Randomized bench for nrx_scandoubler with a cycle-count reference model of the doubled output.
module tb_nrx_scandoubler;

    logic       VCLKx4 = 1'b0;
    logic       RESET  = 1'b1;
    logic       PIXCE  = 1'b0;
    logic [8:0] HPOS   = 9'd0;
    logic [8:0] VPOS   = 9'd0;
    logic [7:0] POUT   = 8'd0;
    logic [7:0] VOUT;
    logic       HSYNC;
    logic       VSYNC;
    logic       DE;
    logic       OCE;
    logic       LOCKED;

    nrx_scandoubler dut (
        .VCLKx4 (VCLKx4),
        .RESET  (RESET),
        .PIXCE  (PIXCE),
        .HPOS   (HPOS),
        .VPOS   (VPOS),
        .POUT   (POUT),
        .VOUT   (VOUT),
        .HSYNC  (HSYNC),
        .VSYNC  (VSYNC),
        .DE     (DE),
        .OCE    (OCE),
        .LOCKED (LOCKED)
    );

    always #20 VCLKx4 = ~VCLKx4;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference state: what the bench has written, and when it last reset / started a line.
    logic [7:0] mem_m   [0:1][0:511];
    bit         valid_m [0:1][0:511];
    int         ls_cyc  = -1000000;
    int         rst_cyc = 0;
    int         vlat_m  = 0;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int         anchor;
        int         d;
        int         n;
        int         oh;
        int         vprev;
        bit         lk;
        bit         rb;
        bit         de_e;
        bit         hs_e;
        bit         vs_e;
        logic [7:0] v_e;
        anchor = (ls_cyc > rst_cyc) ? ls_cyc : rst_cyc;
        lk     = ls_cyc > rst_cyc;
        check_val("oce", 16'(OCE), 16'((cyc - anchor - 1) % 2));
        check_val("locked", 16'(LOCKED), 16'(lk));
        if (!lk) begin
            check_val("vout_blank", 16'(VOUT), 16'd0);
            check_val("de_blank", 16'(DE), 16'd0);
            check_val("hsync_idle", 16'(HSYNC), 16'd1);
            check_val("vsync_idle", 16'(VSYNC), 16'd1);
            return;
        end
        d = cyc - ls_cyc - 1;
        if (d < 2) return;
        n     = d / 2 - 1;
        oh    = n % 384;
        rb    = ~vlat_m[0];
        vprev = (vlat_m + 511) % 512;
        de_e  = (oh < 288) && (vprev < 224);
        hs_e  = !((oh >= 304) && (oh < 336));
        vs_e  = !((vlat_m >= 240) && (vlat_m < 242));
        v_e   = de_e ? mem_m[rb][oh] : 8'd0;
        check_val("de", 16'(DE), 16'(de_e));
        check_val("hsync", 16'(HSYNC), 16'(hs_e));
        check_val("vsync", 16'(VSYNC), 16'(vs_e));
        if (!de_e || valid_m[rb][oh]) begin
            check_val("vout", 16'(VOUT), 16'(v_e));
        end
    endtask

    task automatic step(input bit rst, input bit pce, input int hpos, input int vpos,
                        input logic [7:0] pout);
        @(negedge VCLKx4);
        cyc++;
        check_outputs();
        RESET = rst;
        PIXCE = pce;
        HPOS  = 9'(hpos);
        VPOS  = 9'(vpos);
        POUT  = pout;
        if (rst) rst_cyc = cyc;
        if (pce && hpos < 288) begin
            mem_m[vpos % 2][hpos]   = pout;
            valid_m[vpos % 2][hpos] = 1'b1;
        end
        if (pce && hpos == 0 && !rst) begin
            ls_cyc = cyc;
            vlat_m = vpos;
        end
    endtask

    // ramp=1 drives POUT=HPOS[7:0]; rst_pix>=0 pulses RESET off-strobe during that pixel.
    task automatic run_line(input int vpos, input int npix, input bit ramp, input int rst_pix);
        logic [7:0] p;
        for (int h = 0; h < npix; h++) begin
            p = ramp ? 8'(h) : 8'($urandom_range(0, 255));
            for (int k = 0; k < 4; k++) begin
                step((h == rst_pix) && (k == 2), k == 0, h, vpos, p);
            end
        end
    endtask

    initial begin
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < 512; a++) valid_m[b][a] = 1'b0;
        end

        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 0, 8'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 0, 0, 8'd0);

        // Strobes without a line start: buffer fills, outputs stay blank.
        for (int h = 5; h < 40; h++) begin
            for (int k = 0; k < 4; k++) step(1'b0, k == 0, h, 7, 8'($urandom_range(0, 255)));
        end

        run_line(8, 384, 1'b0, -1);
        run_line(9, 384, 1'b0, -1);
        run_line(10, 384, 1'b1, -1);
        run_line(11, 384, 1'b0, -1);
        run_line(12, 384, 1'b0, -1);

        run_line(13, 384, 1'b0, 50);
        run_line(14, 384, 1'b0, -1);
        run_line(15, 384, 1'b1, -1);

        run_line(16, 292, 1'b0, -1);
        run_line(17, 384, 1'b0, -1);
        run_line(18, 400, 1'b0, -1);
        run_line(19, 384, 1'b0, -1);

        for (int v = 238; v < 244; v++) run_line(v, 384, 1'b0, -1);
        for (int v = 222; v < 226; v++) run_line(v, 384, 1'b0, -1);
        run_line(0, 384, 1'b0, -1);
        run_line(1, 384, 1'b0, -1);

        for (int i = 0; i < 1700; i++) step(1'b0, 1'b0, 0, 1, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
